add_unit_arbiter: RTL and testbench
===================================

// Module: add_unit_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer that shares one 32-bit add/subtract unit between two requesters.
//   - Operation: result = A + B, or A - B via B xor cin, cin=1.
//   - Accepts one operation at a time over a valid/ready handshake.
//   - Drives the shared unit's operand/cin inputs from registers and waits ADD_LATENCY cycles.
//   - Captures result and overflow, then returns them with the requester id.
//   - Sits between the two datapath clients and the shared add unit.
// PARAMETERS
//   WIDTH        32  operand/result width; must match the shared add unit
//   ADD_LATENCY  1   cycles operands are held before capture; legal 1..15
// PORTS
//   clock          in   1      single clock, rising edge
//   reset_n        in   1      asynchronous, active-low reset
//   req0_valid     in   1      requester 0 has an operation
//   req0_ready     out  1      requester 0 operation accepted this cycle
//   req0_a         in   WIDTH  requester 0 operand A
//   req0_b         in   WIDTH  requester 0 operand B
//   req0_sub       in   1      requester 0: 1=subtract, 0=add
//   req1_valid     in   1      requester 1 has an operation
//   req1_ready     out  1      requester 1 operation accepted this cycle
//   req1_a         in   WIDTH  requester 1 operand A
//   req1_b         in   WIDTH  requester 1 operand B
//   req1_sub       in   1      requester 1: 1=subtract, 0=add
//   alu_a          out  WIDTH  registered operand A to shared unit
//   alu_b          out  WIDTH  registered operand B to shared unit
//   alu_cin        out  1      registered cin = sub flag of granted request
//   alu_result     in   WIDTH  shared unit result
//   alu_overflow   in   1      shared unit signed overflow
//   resp_valid     out  1      response available
//   resp_ready     in   1      consumer takes response
//   resp_id        out  1      requester that issued the operation
//   resp_result    out  WIDTH  captured result
//   resp_overflow  out  1      captured overflow
// BEHAVIOUR
//   Reset (reset_n=0, async):
//     - state=IDLE, last_grant=1, cnt=0.
//     - All outputs 0: alu_*, resp_*, both readys.
//     - Reset mid-operation drops the in-flight op; no response is ever produced for it.
//   FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//     - grant = round-robin: if both valid, pick !last_grant; else the single valid one.
//     - reqN_ready = (state==IDLE) & reqN_valid & grant==N; combinational, at most one high.
//     - On accept at edge T: latch a/b/sub into alu_*, set resp_id=N, last_grant=N, cnt=0, go EXEC.
//     - No valids: stay IDLE; alu_* hold previous values.
//   EXEC:
//     - alu_* stable from T+1; cnt increments each cycle.
//     - When cnt==ADD_LATENCY-1: capture alu_result/alu_overflow into resp_result/resp_overflow, go RESP.
//     - Capture occurs at edge T+ADD_LATENCY; resp_valid=1 from cycle T+ADD_LATENCY+1.
//   RESP:
//     - resp_valid=1; resp_* stable until resp_ready=1.
//     - On handshake: resp_valid=0 next cycle, go IDLE.
//     - No new accept in the handshake cycle; both readys are 0 outside IDLE.
//   Rules:
//     - Back-to-back throughput is one op per ADD_LATENCY+2 cycles.
//     - Request inputs are sampled only in the accept cycle; requesters hold valid and data until ready.
//     - Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
//     - No starvation.
// TESTING
//   1. Reset, then req0 add 5+7, ADD_LATENCY=1 -> req0_ready same cycle;
//      resp_valid 2 cycles later: id=0, result=12, ovf=0.
//   2. req1 sub 3-5 -> alu_cin=1; result=32'hFFFFFFFE, ovf=0, id=1.
//   3. req0 add 32'h7FFFFFFF+1 -> result=32'h80000000, ovf=1.
//      req0 sub 32'h80000000-1 -> ovf=1.
//   4. Both valid continuously for 4 ops -> grants 0,1,0,1.
//      Responses are in issue order with matching ids.
//   5. Hold resp_ready=0 for 5 cycles -> resp_* stable, both readys 0.
//      Release -> next accept one cycle later.
//   6. Assert reset_n=0 during EXEC -> outputs 0 immediately, no stale response after release.
//      ADD_LATENCY=3 run -> capture at T+3, resp_valid at T+4.

Source files
------------

// File: rtl/add_unit_arbiter.sv
// add_unit_arbiter
// Round-robin arbiter and sequencer sharing one add/subtract unit between
// two requesters. One operation is in flight at a time. Operands are held
// on alu_* for ADD_LATENCY cycles, then the result is captured and returned
// with the id of the requester that issued it.
module add_unit_arbiter #(
    parameter int WIDTH       = 32,
    parameter int ADD_LATENCY = 1    // legal range 1..15
) (
    input  logic             clock,
    input  logic             reset_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Terminal count of the EXEC phase; capture happens on the edge that
    // leaves EXEC, which is ADD_LATENCY edges after the accept edge.
    localparam logic [3:0] LAST_CNT = 4'(ADD_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic [3:0] cnt;
    logic       grant;
    logic       accept;
    logic       cnt_done;

    // Round-robin choice: alternate when both ask, otherwise serve the asker.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Readys are gated with reset_n so that nothing is accepted, nor
    // advertised, while reset is held.
    assign req0_ready = reset_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = reset_n && (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;
    assign cnt_done   = (cnt == LAST_CNT);
    assign resp_valid = (state == RESP);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples pre-edge values regardless of order.
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)     state_next = EXEC;
            EXEC: if (cnt_done)   state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Operand latch on accept, latency count in EXEC, result capture on exit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_cin       <= 1'b0;
            resp_id       <= 1'b0;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            last_grant    <= 1'b1;
            cnt           <= '0;
        end else begin
            if (accept) begin
                alu_a      <= grant ? req1_a   : req0_a;
                alu_b      <= grant ? req1_b   : req0_b;
                alu_cin    <= grant ? req1_sub : req0_sub;
                resp_id    <= grant;
                last_grant <= grant;
                cnt        <= '0;
            end
            if (state == EXEC) begin
                cnt <= cnt + 4'd1;
                if (cnt_done) begin
                    resp_result   <= alu_result;
                    resp_overflow <= alu_overflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_unit_arbiter.sv
// tb_add_unit_arbiter
// Directed bench for add_unit_arbiter: a table of single operations with
// hand-computed results, then fairness, back-pressure, mid-operation reset
// and a longer-latency instance. The shared add unit is modelled here.
module tb_add_unit_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;

    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_cin, alu_overflow;
    logic        resp_valid, resp_ready, resp_id, resp_overflow;
    logic [31:0] resp_result;

    // Second instance with ADD_LATENCY=3; only requester 0 is used.
    logic        l3_req0_valid, l3_req0_ready;
    logic        l3_req1_ready;
    logic [31:0] l3_req0_a, l3_req0_b;
    logic        l3_req0_sub;
    logic [31:0] l3_alu_a, l3_alu_b, l3_alu_result;
    logic        l3_alu_cin, l3_alu_overflow;
    logic        l3_resp_valid, l3_resp_ready, l3_resp_id, l3_resp_overflow;
    logic [31:0] l3_resp_result;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    // Shared add unit model: A + (B ^ {cin}) + cin with signed overflow.
    logic [31:0] bx, l3_bx;
    assign bx            = alu_b ^ {32{alu_cin}};
    assign alu_result    = alu_a + bx + {31'd0, alu_cin};
    assign alu_overflow  = (alu_a[31] == bx[31]) && (alu_result[31] != alu_a[31]);
    assign l3_bx         = l3_alu_b ^ {32{l3_alu_cin}};
    assign l3_alu_result = l3_alu_a + l3_bx + {31'd0, l3_alu_cin};
    assign l3_alu_overflow = (l3_alu_a[31] == l3_bx[31]) &&
                             (l3_alu_result[31] != l3_alu_a[31]);

    add_unit_arbiter #(.WIDTH(32), .ADD_LATENCY(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_overflow(resp_overflow)
    );

    add_unit_arbiter #(.WIDTH(32), .ADD_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready),
        .req0_a(l3_req0_a), .req0_b(l3_req0_b), .req0_sub(l3_req0_sub),
        .req1_valid(1'b0), .req1_ready(l3_req1_ready),
        .req1_a(32'd0), .req1_b(32'd0), .req1_sub(1'b0),
        .alu_a(l3_alu_a), .alu_b(l3_alu_b), .alu_cin(l3_alu_cin),
        .alu_result(l3_alu_result), .alu_overflow(l3_alu_overflow),
        .resp_valid(l3_resp_valid), .resp_ready(l3_resp_ready), .resp_id(l3_resp_id),
        .resp_result(l3_resp_result), .resp_overflow(l3_resp_overflow)
    );

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
        end
    endtask

    // One operation from one requester; starts and ends at a falling edge.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        set_req(v.id, 1'b1, v.a, v.b, v.sub);
        resp_ready = 1'b1;
        #1;
        check({tag, "_ready"}, {30'd0, req1_ready, req0_ready},
              v.id ? 32'd2 : 32'd1);
        @(posedge clock);
        #1 set_req(v.id, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clock);
        check({tag, "_exec_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_alu_a"}, alu_a, v.a);
        check({tag, "_alu_b"}, alu_b, v.b);
        check({tag, "_alu_cin"}, {31'd0, alu_cin}, {31'd0, v.sub});
        @(negedge clock);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_resp_id"}, {31'd0, resp_id}, {31'd0, v.id});
        check({tag, "_resp_result"}, resp_result, v.res);
        check({tag, "_resp_ovf"}, {31'd0, resp_overflow}, {31'd0, v.ovf});
        @(negedge clock);
        check({tag, "_done"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd5,          32'd7,          1'b0, 32'd12,         1'b0};
        vecs[1] = '{1'b1, 32'd3,          32'd5,          1'b1, 32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b1};
        vecs[3] = '{1'b0, 32'h8000_0000,  32'd1,          1'b1, 32'h7FFF_FFFF,  1'b1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b0};
        vecs[5] = '{1'b1, 32'd0,          32'h8000_0000,  1'b1, 32'h8000_0000,  1'b1};
        vecs[6] = '{1'b0, 32'h1234_5678,  32'h1111_1111,  1'b0, 32'h2345_6789,  1'b0};

        reset_n = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        resp_ready    = 1'b1;
        l3_req0_valid = 1'b0; l3_req0_a = 32'd0; l3_req0_b = 32'd0; l3_req0_sub = 1'b0;
        l3_resp_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_alu_a", alu_a, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Table of single operations.
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset drives alu_* back to zero and restores last_grant=1.
        reset_n = 1'b0;
        #1;
        check("reset2_alu_a", alu_a, 32'd0);
        check("reset2_alu_b", alu_b, 32'd0);
        check("reset2_result", resp_result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Fairness: both continuously valid, grants 0,1,0,1.
        set_req(1'b0, 1'b1, 32'd10,  32'd20, 1'b0);
        set_req(1'b1, 1'b1, 32'd100, 32'd30, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fair%0d_ready", i), {30'd0, req1_ready, req0_ready},
                  (i % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clock);
            check($sformatf("fair%0d_exec_ready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clock);
            check($sformatf("fair%0d_id", i), {31'd0, resp_id}, 32'(i % 2));
            check($sformatf("fair%0d_result", i), resp_result,
                  (i % 2 == 0) ? 32'd30 : 32'd70);
            check($sformatf("fair%0d_resp_ready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clock);
        end
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clock);

        // Back-pressure: response held 5 cycles, requester 1 waits.
        resp_ready = 1'b0;
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 1'b0);
        #1 check("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clock);
        #1;
        set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        set_req(1'b1, 1'b1, 32'd50, 32'd8, 1'b1);
        @(negedge clock);
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d_valid", k), {31'd0, resp_valid}, 32'd1);
            check($sformatf("bp%0d_result", k), resp_result, 32'd3);
            check($sformatf("bp%0d_id", k), {31'd0, resp_id}, 32'd0);
            check($sformatf("bp%0d_req1_ready", k), {31'd0, req1_ready}, 32'd0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        check("bp_release_ready", {31'd0, req1_ready}, 32'd1);
        check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clock);
        #1 set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("bp_next_id", {31'd0, resp_id}, 32'd1);
        check("bp_next_result", resp_result, 32'd42);
        @(negedge clock);

        // Reset during EXEC drops the operation.
        set_req(1'b0, 1'b1, 32'd9, 32'd9, 1'b0);
        @(posedge clock);
        #1 set_req(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clock);
        check("rst_exec_alu_a", alu_a, 32'd9);
        set_req(1'b1, 1'b1, 32'd4, 32'd4, 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clock);
        set_req(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("rst_no_stale%0d", k), {31'd0, resp_valid}, 32'd0);
        end

        // ADD_LATENCY=3: capture at T+3, resp_valid from T+4.
        l3_req0_valid = 1'b1; l3_req0_a = 32'h10; l3_req0_b = 32'h20; l3_req0_sub = 1'b1;
        #1 check("l3_ready", {31'd0, l3_req0_ready}, 32'd1);
        @(posedge clock);
        #1 l3_req0_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            check($sformatf("l3_exec%0d_valid", k), {31'd0, l3_resp_valid}, 32'd0);
        end
        @(negedge clock);
        check("l3_resp_valid", {31'd0, l3_resp_valid}, 32'd1);
        check("l3_resp_result", l3_resp_result, 32'hFFFF_FFF0);
        check("l3_resp_ovf", {31'd0, l3_resp_overflow}, 32'd0);
        check("l3_resp_id", {31'd0, l3_resp_id}, 32'd0);
        @(negedge clock);
        check("l3_done", {31'd0, l3_resp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
